// File: rtl/ex_issue_ctrl_pkg.sv
// Shared definitions for the EX issue controller: default sizes, FSM encoding, issue-entry width.
// Operand width follows `REGISTER_WIDTH (16 when the build does not set it).
`ifndef REGISTER_WIDTH
`define REGISTER_WIDTH 16
`endif
package ex_issue_ctrl_pkg;
  localparam int EXQ_DEPTH  = 4;
  localparam int EXQ_TAG_W  = 4;
  localparam int EX_LATENCY = 2;
  localparam int EXQ_REG_WD = `REGISTER_WIDTH;
  localparam int CTRL_W     = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic int entry_w(input int reg_wd, input int tag_w);
    return 3 * reg_wd + CTRL_W + tag_w;
  endfunction
endpackage

// File: rtl/ex_issue_ctrl_if.sv
// Decode -> issue-controller handshake: one decoded op per transfer (valid & ready).
interface ex_issue_ctrl_if import ex_issue_ctrl_pkg::*; #(
  parameter int REG_WD = EXQ_REG_WD,
  parameter int TAG_W  = EXQ_TAG_W
);
  logic              dec_valid;
  logic              dec_ready;
  logic [REG_WD-1:0] dec_src1;
  logic [REG_WD-1:0] dec_src2;
  logic [REG_WD-1:0] dec_imm;
  logic [CTRL_W-1:0] dec_control;
  logic [TAG_W-1:0]  dec_tag;

  modport master (output dec_valid, dec_src1, dec_src2, dec_imm, dec_control, dec_tag,
                  input  dec_ready);
  modport slave  (input  dec_valid, dec_src1, dec_src2, dec_imm, dec_control, dec_tag,
                  output dec_ready);
endinterface

// File: rtl/ex_issue_ctrl_fifo.sv
// exq_fifo: synchronous FIFO with push/pop/clear; full/empty/count come straight from registers.
module exq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // DEPTH is a power of two, so natural pointer overflow is the mod-DEPTH wrap
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: queues decoded ops, issues one per cycle, tracks them through EX.
// FIFO_BYPASS_EN: an op arriving at an empty queue goes straight to the issue registers.
module ex_issue_ctrl import ex_issue_ctrl_pkg::*; #(
  parameter int DEPTH  = EXQ_DEPTH,
  parameter int TAG_W  = EXQ_TAG_W,
  parameter int EX_LAT = EX_LATENCY,
  parameter int REG_WD = EXQ_REG_WD
) (
  input  logic              clock,
  input  logic              reset,
  ex_issue_ctrl_if.slave    dec,
  input  logic              hold,
  input  logic              flush,
  output logic              enable_ex,
  output logic [REG_WD-1:0] src1,
  output logic [REG_WD-1:0] src2,
  output logic [REG_WD-1:0] imm,
  output logic [CTRL_W-1:0] control_in,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic              busy
);
  localparam int EW = entry_w(REG_WD, TAG_W);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e state_q, state_d;
  logic   rdy_en_q;
  logic   acc, byp, issue, push;
  logic   full, empty;
  logic [CW-1:0] count;
  logic [EW-1:0] fifo_din, fifo_dout, iss_ent;

  logic [REG_WD-1:0] src1_q, src1_d, src2_q, src2_d, imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  // stage 0 is the issue strobe itself; stage EX_LAT lines up with aluout/carry
  logic [EX_LAT:0]            vld_pipe_q, vld_pipe_d;
  logic [EX_LAT:0][TAG_W-1:0] tag_pipe_q, tag_pipe_d;

  assign fifo_din = {dec.dec_src1, dec.dec_src2, dec.dec_imm, dec.dec_control, dec.dec_tag};

  exq_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (issue),
    .clear (flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    dec.dec_ready = rdy_en_q && !full && (state_q != S_DRAIN) && !flush;
    acc           = dec.dec_valid && dec.dec_ready;
`ifdef FIFO_BYPASS_EN
    byp           = acc && empty && !hold;
`else
    byp           = 1'b0;
`endif
    // IDLE with a non-empty queue is already on its way to RUN; issuing there keeps accept->issue at one edge
    issue         = (state_q != S_DRAIN) && !empty && !hold && !flush;
    push          = acc && !byp;
    iss_ent       = byp ? fifo_din : fifo_dout;
  end

  always_comb begin
    src1_d = src1_q;
    src2_d = src2_q;
    imm_d  = imm_q;
    ctrl_d = ctrl_q;
    if (issue || byp) {src1_d, src2_d, imm_d, ctrl_d} = iss_ent[EW-1:TAG_W];
    vld_pipe_d = {vld_pipe_q[EX_LAT-1:0], issue || byp};
    tag_pipe_d = {tag_pipe_q[EX_LAT-1:0], (issue || byp) ? iss_ent[TAG_W-1:0] : TAG_W'(0)};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!empty || byp) state_d = S_RUN;
      S_RUN:   if (empty && !(|vld_pipe_q)) state_d = S_IDLE;
      S_DRAIN: if (!(|vld_pipe_q)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_DRAIN;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      imm_q      <= '0;
      ctrl_q     <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  assign enable_ex  = vld_pipe_q[0];
  assign src1       = src1_q;
  assign src2       = src2_q;
  assign imm        = imm_q;
  assign control_in = ctrl_q;
  assign res_valid  = vld_pipe_q[EX_LAT];
  assign res_tag    = tag_pipe_q[EX_LAT];
  assign busy       = (count != '0) || (|vld_pipe_q);
endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Scoreboard bench for ex_issue_ctrl: ops accepted are queued in a model, issue/results checked in order.
module tb_ex_issue_ctrl;
  import ex_issue_ctrl_pkg::*;
  localparam int RW    = EXQ_REG_WD;
  localparam int TW    = EXQ_TAG_W;
  localparam int LAT   = EX_LATENCY;
  localparam int DEPTH = EXQ_DEPTH;
`ifdef FIFO_BYPASS_EN
  localparam int MIN_ISS = 1;
`else
  localparam int MIN_ISS = 2;
`endif

  logic clock = 1'b0, reset = 1'b1, hold = 1'b0, flush = 1'b0;
  logic          enable_ex, res_valid, busy;
  logic [RW-1:0] src1, src2, imm;
  logic [6:0]    control_in;
  logic [TW-1:0] res_tag;

  ex_issue_ctrl_if #(.REG_WD(RW), .TAG_W(TW)) dif ();

  ex_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TW), .EX_LAT(LAT), .REG_WD(RW)) dut (
    .clock(clock), .reset(reset), .dec(dif), .hold(hold), .flush(flush),
    .enable_ex(enable_ex), .src1(src1), .src2(src2), .imm(imm), .control_in(control_in),
    .res_valid(res_valid), .res_tag(res_tag), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [RW-1:0] s1, s2, im;
    logic [6:0]    c;
    logic [TW-1:0] t;
    int            acc;
    bit            exact;
  } op_t;
  typedef struct {
    logic [TW-1:0] t;
    int            iss;
  } res_t;

  op_t  pend[$];
  res_t resq[$];
  int   errs = 0, checks = 0, cyc = 0, n_res = 0;
  bit   hold_prev = 0, drain_chk = 0, exact_next = 0, acc_seen = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // monitor: compares DUT against the queued model every cycle, away from the rising edge
  always @(negedge clock) begin : mon
    op_t  o;
    res_t r;
    cyc++;
    if (reset) begin
      chk("busy", busy, (pend.size() != 0 || resq.size() != 0));
      if (res_valid) begin
        n_res++;
        if (resq.size() == 0) chk("res_unexpected", res_valid, 0);
        else begin
          r = resq.pop_front();
          chk("res_tag", res_tag, r.t);
          chk("res_latency", cyc - r.iss, LAT);
        end
      end
      if (enable_ex) begin
        chk("issue_after_hold", hold_prev, 0);
        if (pend.size() == 0) chk("issue_unexpected", enable_ex, 0);
        else begin
          o = pend.pop_front();
          chk("issue_operands", {src1, src2, imm, control_in}, {o.s1, o.s2, o.im, o.c});
          if (o.exact) chk("issue_latency", cyc - o.acc, MIN_ISS);
          else         chk("issue_latency_min", (cyc - o.acc) >= MIN_ISS, 1);
          r.t = o.t; r.iss = cyc;
          resq.push_back(r);
        end
      end
      if (drain_chk) begin
        if (resq.size() == 0) drain_chk = 0;
        else chk("ready_in_drain", dif.dec_ready, 0);
      end
      if (dif.dec_valid && dif.dec_ready) begin
        o.s1 = dif.dec_src1; o.s2 = dif.dec_src2; o.im = dif.dec_imm;
        o.c = dif.dec_control; o.t = dif.dec_tag; o.acc = cyc; o.exact = exact_next;
        pend.push_back(o);
        acc_seen = 1;
      end
      if (flush) begin
        pend.delete();
        drain_chk = 1;
      end
      hold_prev = hold;
    end
  end

  task automatic rand_fields();
    dif.dec_src1    = RW'($urandom);
    dif.dec_src2    = RW'($urandom);
    dif.dec_imm     = RW'($urandom);
    dif.dec_control = 7'($urandom);
    dif.dec_tag     = TW'($urandom);
  endtask

  task automatic push_op(input logic [RW-1:0] a, input logic [RW-1:0] b, input logic [RW-1:0] im,
                         input logic [6:0] c, input logic [TW-1:0] t);
    dif.dec_valid = 1; dif.dec_src1 = a; dif.dec_src2 = b; dif.dec_imm = im;
    dif.dec_control = c; dif.dec_tag = t;
    acc_seen = 0;
    for (int k = 0; k < 40 && !acc_seen; k++) @(posedge clock);
    #1;
    if (!acc_seen) chk("accept_timeout", acc_seen, 1);
    dif.dec_valid = 0;
  endtask

  // hold high, offer ops until the queue stops accepting; leaves dec_valid high with one op pending
  task automatic fill(output int n);
    n = 0; hold = 1; rand_fields(); dif.dec_valid = 1;
    repeat (DEPTH + 4) begin
      acc_seen = 0;
      @(posedge clock); #1;
      if (acc_seen) begin n++; rand_fields(); end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int n, n0;
    dif.dec_valid = 0; rand_fields();
    #1 reset = 0;
    @(negedge clock);
    chk("reset_outputs", {enable_ex, res_valid, busy, dif.dec_ready, src1, src2, imm, control_in, res_tag}, '0);
    repeat (2) @(posedge clock);
    #2 reset = 1;
    idle(1);
    chk("ready_after_reset", dif.dec_ready, 1);

    // single op into an empty controller: exact issue and result timing
    exact_next = 1;
    push_op(16'd5, 16'd3, 16'd0, 7'h01, 4'd1);
    exact_next = 0;
    idle(8);

    // back-to-back ops
    for (int i = 0; i < 6; i++) push_op(RW'($urandom), RW'($urandom), RW'($urandom), 7'($urandom), TW'(i));
    idle(10);

    // hold: queue fills, nothing issues, then a full-rate burst
    fill(n);
    chk("fill_count", n, DEPTH);
    dif.dec_valid = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clock); chk("hold_no_issue", enable_ex, 0); end
    @(posedge clock); #1 hold = 0;
    @(negedge clock);
    for (int i = 0; i < DEPTH; i++) begin @(negedge clock); chk("burst_issue", enable_ex, 1); end
    idle(8);

    // flush with ops queued and two in flight
    fill(n);
    hold = 0;
    idle(1);
    idle(1);
    n0 = n_res; hold = 1; flush = 1;
    idle(1);
    flush = 0; dif.dec_valid = 0; hold = 0;
    idle(10);
    chk("flush_results", n_res - n0, 2);
    chk("ready_after_drain", dif.dec_ready, 1);
    chk("busy_after_drain", busy, 0);

    // randomized traffic with hold and flush
    for (int i = 0; i < 400; i++) begin
      dif.dec_valid = ($urandom % 10) < 7;
      rand_fields();
      hold  = ($urandom % 6) == 0;
      flush = ($urandom % 40) == 0;
      idle(1);
    end
    dif.dec_valid = 0; hold = 0; flush = 0;
    idle(12);
    chk("model_drained", pend.size() + resq.size(), 0);

    // asynchronous reset with ops in flight
    for (int i = 0; i < 3; i++) push_op(RW'($urandom), RW'($urandom), RW'($urandom), 7'($urandom), TW'(i));
    @(posedge clock);
    #3 reset = 0;
    n0 = n_res;
    #1 chk("async_reset_outputs",
           {enable_ex, res_valid, busy, dif.dec_ready, src1, src2, imm, control_in, res_tag}, '0);
    pend.delete(); resq.delete(); drain_chk = 0;
    repeat (2) @(posedge clock);
    #2 reset = 1;
    idle(8);
    chk("no_res_after_reset", n_res - n0, 0);
    chk("busy_after_reset", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errs);
    $fatal(1);
  end
endmodule
